// File: rtl/stopwatch_pkg.sv
// Shared types and BCD helpers for the stopwatch timing core.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        STOP    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

    localparam logic [3:0] BCD_MAX  = 4'h9;
    localparam logic [3:0] BCD_ZERO = 4'h0;

    // Clamp a nibble into the legal BCD range.
    function automatic logic [3:0] bcd_sat(input logic [3:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the ripple increment/decrement chain; carry doubles as borrow.
module bcd_digit_step
    import stopwatch_pkg::*;
(
    input  logic [3:0] din,
    input  logic       en,
    input  logic       down,
    output logic [3:0] dout,
    output logic       carry
);

    always_comb begin
        dout  = din;
        carry = 1'b0;
        if (en) begin
            if (down) begin
                if (din == BCD_ZERO) begin
                    dout  = BCD_MAX;
                    carry = 1'b1;
                end else begin
                    dout = din - 4'd1;
                end
            end else begin
                if (din == BCD_MAX) begin
                    dout  = BCD_ZERO;
                    carry = 1'b1;
                end else begin
                    dout = din + 4'd1;
                end
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// N-digit BCD up/down stopwatch core: run FSM, tick divider, lap capture/hold, expiry.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned TICK_DIV = 120000,
    parameter int unsigned LAP_HOLD = 200
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_value,
    input  logic                count_down,
    input  logic                lap,
    output logic [4*DIGITS-1:0] value,
    output logic [4*DIGITS-1:0] display,
    output logic                running,
    output logic                lap_active,
    output logic                wrap,
    output logic                expired
);

    localparam int unsigned W     = 4 * DIGITS;
    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned LT_W  = $clog2(LAP_HOLD + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [LT_W-1:0]  LAP_INIT = LT_W'(LAP_HOLD);

    state_e            state_q, state_d;
    logic [W-1:0]      value_q, value_d;
    logic [W-1:0]      lap_value_q;
    logic [LT_W-1:0]   lap_timer_q;
    logic [DIV_W-1:0]  div_q;
    logic              wrap_q, wrap_d;
    logic              expired_q, expired_d;

    logic [W-1:0]      step_value;
    logic [DIGITS:0]   carry_chain;
    logic [W-1:0]      load_sat;
    logic              cmd_halt;
    logic              tick;
    logic              value_zero;
    logic              step_zero;

    // Ripple carry/borrow chain across digits, least significant first.
    assign carry_chain[0] = 1'b1;

    for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
        bcd_digit_step u_digit (
            .din   (value_q[4*i +: 4]),
            .en    (carry_chain[i]),
            .down  (count_down),
            .dout  (step_value[4*i +: 4]),
            .carry (carry_chain[i+1])
        );
    end

    always_comb begin
        load_sat = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            load_sat[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
        end
    end

    assign cmd_halt   = clear | load | stop;
    assign tick       = (state_q == RUN) && (div_q == DIV_LAST) && !cmd_halt;
    assign value_zero = (value_q == '0);
    assign step_zero  = (step_value == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= STOP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (cmd_halt) begin
            state_d = STOP;
        end else if (start && (state_q == STOP) && !(count_down && value_zero)) begin
            state_d = RUN;
        end else if (tick && count_down && !value_zero && step_zero) begin
            state_d = EXPIRED;
        end
    end

    // Output decode plus next value and event pulses.
    always_comb begin
        running   = (state_q == RUN);
        value_d   = value_q;
        wrap_d    = 1'b0;
        expired_d = 1'b0;
        if (clear) begin
            value_d = '0;
        end else if (load) begin
            value_d = load_sat;
        end else if (tick) begin
            if (!count_down) begin
                value_d = step_value;
                wrap_d  = carry_chain[DIGITS];
            end else if (!value_zero) begin
                value_d   = step_value;
                expired_d = step_zero;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_q   <= '0;
            wrap_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            value_q   <= value_d;
            wrap_q    <= wrap_d;
            expired_q <= expired_d;
        end
    end

    // Divider only advances while running uninterrupted; otherwise parked at zero.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            div_q <= '0;
        end else if ((state_q == RUN) && !cmd_halt) begin
            div_q <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end else begin
            div_q <= '0;
        end
    end

    // Lap captures the pre-update value; clear overrides any capture.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            lap_value_q <= '0;
            lap_timer_q <= '0;
        end else if (clear) begin
            lap_timer_q <= '0;
        end else if (lap) begin
            lap_value_q <= value_q;
            lap_timer_q <= LAP_INIT;
        end else if (lap_timer_q != '0) begin
            lap_timer_q <= lap_timer_q - LT_W'(1);
        end
    end

    assign value      = value_q;
    assign wrap       = wrap_q;
    assign expired    = expired_q;
    assign lap_active = (lap_timer_q != '0);
    assign display    = lap_active ? lap_value_q : value_q;

endmodule
